// File: rtl/memory_ctrl_if.sv
// Bundle between the instruction sequencer and its surroundings.
//  instr_valid/instr_ready/instr    : instruction handshake from fetch
//  reg_a_out/reg_d_out/reg_m_out    : current A, D and RAM[A] from the memory block
//  reg_a_en/reg_d_en/reg_m_en       : one-cycle write strobes to the memory block
//  data_in                          : write data to the memory block
//  pc                               : address of the next instruction
// master = controller side, slave = fetch/memory side.
interface memory_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] reg_a_out;
    logic [15:0] reg_d_out;
    logic [15:0] reg_m_out;
    logic        reg_a_en;
    logic        reg_d_en;
    logic        reg_m_en;
    logic [15:0] data_in;
    logic [15:0] pc;

    modport master (
        input  instr_valid, instr, reg_a_out, reg_d_out, reg_m_out,
        output instr_ready, reg_a_en, reg_d_en, reg_m_en, data_in, pc
    );

    modport slave (
        output instr_valid, instr, reg_a_out, reg_d_out, reg_m_out,
        input  instr_ready, reg_a_en, reg_d_en, reg_m_en, data_in, pc
    );
endinterface

// File: rtl/memory_ctrl.sv
// Hack instruction sequencer for the A/D/M memory block.
// Accepts one instruction per 2+SETTLE cycles, evaluates it with the Hack ALU and
// issues one-cycle registered write strobes plus write data, then updates pc.
//  clk  : system clock, rising edge
//  rst  : asynchronous active-high reset
//  bus  : memory_ctrl_if.master (handshake, register readback, strobes, data_in, pc)
module memory_ctrl #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int unsigned SETTLE   = 1
) (
    input logic           clk,
    input logic           rst,
    memory_ctrl_if.master bus
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StExec, StSettle} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     ir_q, ir_d;
    logic            a_en_q, a_en_d;
    logic            d_en_q, d_en_d;
    logic            m_en_q, m_en_d;
    logic [15:0]     data_q, data_d;
    logic [15:0]     pc_q, pc_d;

    logic [15:0] alu_x, alu_y, alu_res;
    logic        accept;
    logic        zr, ng, taken;

    // ALU evaluated on the incoming word: registers are stable from IDLE through EXEC,
    // so computing at accept lets the strobes and data be registered into EXEC.
    always_comb begin
        alu_x = bus.reg_d_out;
        alu_y = bus.instr[12] ? bus.reg_m_out : bus.reg_a_out;
        if (bus.instr[11]) alu_x = '0;
        if (bus.instr[10]) alu_x = ~alu_x;
        if (bus.instr[9])  alu_y = '0;
        if (bus.instr[8])  alu_y = ~alu_y;
        alu_res = bus.instr[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (bus.instr[6])  alu_res = ~alu_res;
    end

    assign accept = (state_q == StIdle) && bus.instr_valid && !rst;

    // Jump resolved in EXEC from the latched word and the result held on data_in;
    // reg_a_out still shows the pre-instruction A here.
    assign zr    = (data_q == 16'h0000);
    assign ng    = data_q[15];
    assign taken = ir_q[15] & ((ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        a_en_d  = 1'b0;
        d_en_d  = 1'b0;
        m_en_d  = 1'b0;
        data_d  = data_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    ir_d    = bus.instr;
                    state_d = StExec;
                    if (!bus.instr[15]) begin
                        data_d = {1'b0, bus.instr[14:0]};
                        a_en_d = 1'b1;
                    end else begin
                        data_d = alu_res;
                        a_en_d = bus.instr[5];
                        d_en_d = bus.instr[4];
                        m_en_d = bus.instr[3];
                    end
                end
            end
            StExec: begin
                state_d = StSettle;
                cnt_d   = '0;
                pc_d    = taken ? bus.reg_a_out : pc_q + 16'd1;
            end
            StSettle: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ir_q    <= '0;
            a_en_q  <= 1'b0;
            d_en_q  <= 1'b0;
            m_en_q  <= 1'b0;
            data_q  <= '0;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            a_en_q  <= a_en_d;
            d_en_q  <= d_en_d;
            m_en_q  <= m_en_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.instr_ready = (state_q == StIdle) && !rst;
    assign bus.reg_a_en    = a_en_q;
    assign bus.reg_d_en    = d_en_q;
    assign bus.reg_m_en    = m_en_q;
    assign bus.data_in     = data_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_memory_ctrl.sv
module tb_memory_ctrl;

    typedef struct {
        logic [15:0] instr;
        logic        a_en;
        logic        d_en;
        logic        m_en;
        logic [15:0] data;
        logic [15:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_ctrl_if bus ();

    memory_ctrl #(
        .PC_RESET (16'h0000),
        .SETTLE   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory block model: A, D and RAM sampled on the same edge (M uses old A).
    logic [15:0] mem_a = '0;
    logic [15:0] mem_d = '0;
    bit   [15:0] ram [65536];

    always @(posedge clk) begin
        if (bus.reg_a_en) mem_a <= bus.data_in;
        if (bus.reg_d_en) mem_d <= bus.data_in;
        if (bus.reg_m_en) ram[mem_a] <= bus.data_in;
    end

    assign bus.reg_a_out = mem_a;
    assign bus.reg_d_out = mem_d;
    assign bus.reg_m_out = ram[mem_a];

    // Reference model state.
    logic [15:0] r_a = '0;
    logic [15:0] r_d = '0;
    logic [15:0] r_pc = '0;
    bit   [15:0] r_ram [65536];

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb_q[$];
    time  t_acc = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [15:0] ins, input logic [15:0] x0,
                                            input logic [15:0] y0);
        logic [15:0] x, y, o;
        x = ins[11] ? 16'h0000 : x0;
        x = ins[10] ? ~x : x;
        y = ins[9] ? 16'h0000 : y0;
        y = ins[8] ? ~y : y;
        o = ins[7] ? x + y : x & y;
        return ins[6] ? ~o : o;
    endfunction

    // Advance the reference by one instruction and return its expected outputs.
    task automatic ref_step(input logic [15:0] ins, output vec_t e);
        logic [15:0] res, old_a;
        logic        z, n, jmp;
        e.instr = ins;
        old_a   = r_a;
        if (!ins[15]) begin
            e.a_en = 1'b1; e.d_en = 1'b0; e.m_en = 1'b0;
            e.data = {1'b0, ins[14:0]};
            e.pc   = r_pc + 16'd1;
            r_a    = e.data;
        end else begin
            res    = ref_alu(ins, r_d, ins[12] ? r_ram[r_a] : r_a);
            z      = (res == 16'h0000);
            n      = res[15];
            jmp    = (ins[2] && n) || (ins[1] && z) || (ins[0] && !n && !z);
            e.a_en = ins[5]; e.d_en = ins[4]; e.m_en = ins[3];
            e.data = res;
            e.pc   = jmp ? old_a : r_pc + 16'd1;
            if (ins[3]) r_ram[old_a] = res;
            if (ins[4]) r_d = res;
            if (ins[5]) r_a = res;
        end
        r_pc = e.pc;
    endtask

    // Issue one instruction; expected values come from the table (use_tab) or the model.
    task automatic issue(input logic [15:0] ins, input bit use_tab, input vec_t tab,
                         input bit chk_gap);
        vec_t e;
        int   n;
        time  prev;
        ref_step(ins, e);
        if (use_tab) e = tab;
        sb_q.push_back(e);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        n = 0;
        while (!bus.instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 8 cycles");
        end
        @(posedge clk);
        prev  = t_acc;
        t_acc = $time;
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = ~ins;  // must not disturb the instruction in flight
        e = sb_q.pop_front();
        if (chk_gap) chk("accept_gap", 16'(t_acc - prev), 16'd30);
        chk("exec_a_en", {15'd0, bus.reg_a_en}, {15'd0, e.a_en});
        chk("exec_d_en", {15'd0, bus.reg_d_en}, {15'd0, e.d_en});
        chk("exec_m_en", {15'd0, bus.reg_m_en}, {15'd0, e.m_en});
        chk("exec_data", bus.data_in, e.data);
        chk("exec_ready", {15'd0, bus.instr_ready}, 16'd0);
        @(posedge clk);
        #1;
        chk("settle_strobes", {13'd0, bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}, 16'd0);
        chk("settle_data_hold", bus.data_in, e.data);
        chk("pc", bus.pc, e.pc);
        @(posedge clk);
        #1;
        chk("idle_ready", {15'd0, bus.instr_ready}, 16'd1);
        chk("readback_a", mem_a, r_a);
        chk("readback_d", mem_d, r_d);
    endtask

    vec_t tab[8];
    vec_t none;

    initial begin
        none = '{16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
        tab[0] = '{16'h1234, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0001};
        tab[1] = '{16'hEC10, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0002};
        tab[2] = '{16'hE7C8, 1'b0, 1'b0, 1'b1, 16'h1235, 16'h0003};
        tab[3] = '{16'hEA87, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234};
        tab[4] = '{16'hE302, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1235};
        tab[5] = '{16'hEEA0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1236};
        tab[6] = '{16'hEA87, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF};
        tab[7] = '{16'h0005, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000};

        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;

        // Reset state.
        #12;
        chk("rst_ready", {15'd0, bus.instr_ready}, 16'd0);
        chk("rst_strobes", {13'd0, bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}, 16'd0);
        chk("rst_data", bus.data_in, 16'h0000);
        chk("rst_pc", bus.pc, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", {15'd0, bus.instr_ready}, 16'd1);

        // Directed vectors, including the pc wrap.
        for (int i = 0; i < 8; i++) begin
            issue(tab[i].instr, 1'b1, tab[i], i > 0);
        end
        chk("ram_1234", ram[16'h1234], 16'h1235);

        // Valid held low: controller idles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready_hold", {15'd0, bus.instr_ready}, 16'd1);
            chk("idle_no_strobe", {13'd0, bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}, 16'd0);
            chk("idle_pc", bus.pc, r_pc);
        end

        // Reset during EXEC of D=A: strobe drops at once, no write lands.
        issue(16'h1111, 1'b0, none, 1'b0);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 16'hEC10;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        chk("rstx_d_en_before", {15'd0, bus.reg_d_en}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstx_d_en_drop", {15'd0, bus.reg_d_en}, 16'd0);
        chk("rstx_pc", bus.pc, 16'h0000);
        chk("rstx_ready", {15'd0, bus.instr_ready}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        r_pc = 16'h0000;
        #1;
        chk("rstx_rel_ready", {15'd0, bus.instr_ready}, 16'd1);
        @(posedge clk);
        #1;
        chk("rstx_d_unchanged", mem_d, r_d);
        chk("rstx_pc_after", bus.pc, 16'h0000);

        // Random instructions against the reference, back to back.
        for (int i = 0; i < 24; i++) begin
            issue(16'($urandom), 1'b0, none, i > 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
